pipe_stage_reg: RTL

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB generation 2).
//  - Single clock; valid/ready handshake on both sides; synchronous flush.
//  - Optional 2-entry skid buffer (SKID=1) so in_ready is a registered signal.
//  - Guarantees zero control bits on bubbles, so no spurious we_reg/dm2reg/jump reaches the

---
 rtl/pipe_stage_reg.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake on both sides.
// SKID=0 keeps a single entry and derives in_ready_o combinationally from
// out_ready_i. SKID=1 adds a second (skid) entry so in_ready_o comes straight
// from a flop and breaks the backpressure timing path. Bubbles carry zero
// control bits, and a saturating counter tracks downstream stall cycles.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W   = 8,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CLR_CTRL = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Head-of-stage view shared by both storage variants.
  logic              out_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;

  logic accept;
  logic retire;

  assign accept = in_valid_i & in_ready;
  assign retire = out_valid & out_ready_i;

  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // State register; in_ready is registered from the next state so it is ready
    // to present as soon as the stage is known not to be full.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= StEmpty;
        in_ready_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        in_ready_q <= (state_d != StFull);
      end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        StEmpty: begin
          if (accept) state_d = StOne;
        end
        StOne: begin
          if (accept && !retire) begin
            state_d = StFull;
          end else if (retire && !accept) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (retire) state_d = StOne;
        end
        default: state_d = StEmpty;
      endcase
      if (flush_i) state_d = StEmpty;
    end

    // Entry steering: main always holds the older entry, skid the younger.
    always_comb begin
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (!flush_i) begin
        unique case (state_q)
          StEmpty: begin
            if (accept) begin
              main_ctrl_d = in_ctrl_i;
              main_data_d = in_data_i;
            end
          end
          StOne: begin
            if (accept && retire) begin
              main_ctrl_d = in_ctrl_i;
              main_data_d = in_data_i;
            end else if (accept) begin
              skid_ctrl_d = in_ctrl_i;
              skid_data_d = in_data_i;
            end
          end
          StFull: begin
            if (retire) begin
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
            end
          end
          default: ;
        endcase
      end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        main_ctrl_q <= '0;
        main_data_q <= '0;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else begin
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
      end
    end

    // Output decode from the current state.
    always_comb begin
      out_valid = (state_q != StEmpty);
      in_ready  = in_ready_q;
      head_ctrl = main_ctrl_q;
      head_data = main_data_q;
    end
  end else begin : g_single
    logic              valid_q, valid_d;
    logic              ready_en_q;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;

    // Next entry: flush wins, then accept (which may also retire), then retire.
    always_comb begin
      valid_d     = valid_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (accept) begin
        valid_d     = 1'b1;
        main_ctrl_d = in_ctrl_i;
        main_data_d = in_data_i;
      end else if (retire) begin
        valid_d = 1'b0;
      end
    end

    // Entry storage; ready_en holds in_ready low until the first edge after reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        valid_q     <= 1'b0;
        ready_en_q  <= 1'b0;
        main_ctrl_q <= '0;
        main_data_q <= '0;
      end else begin
        valid_q     <= valid_d;
        ready_en_q  <= 1'b1;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
      end
    end

    // Combinational backpressure: a held entry leaving this cycle frees the slot.
    always_comb begin
      out_valid = valid_q;
      in_ready  = ready_en_q & (~valid_q | out_ready_i);
      head_ctrl = main_ctrl_q;
      head_data = main_data_q;
    end
  end

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where an entry is held back by downstream.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Bubbles never carry control bits downstream when CLR_CTRL is set.
  always_comb begin
    in_ready_o  = in_ready;
    out_valid_o = out_valid;
    out_data_o  = head_data;
    out_ctrl_o  = ((CLR_CTRL != 0) && !out_valid) ? '0 : head_ctrl;
    stall_cnt_o = stall_cnt_q;
  end

endmodule
